window_gen_3x3: RTL

- Streaming 3x3 sliding-window generator for the binary-pixel CNN datapath.
- Accepts one 1-bit pixel per handshake beat in raster order and buffers two image lines.
- Emits every fully-interior 3x3 window as a 9-bit vector, no padding, stride 1.
- Sits directly upstream of MAC_UNIT: out_win feeds MAC_UNIT input a[8:0] unchanged.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/line_buffer.sv | 33 +++
 rtl/window_gen_3x3.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the binary-pixel CNN datapath.
//   - Default image geometry (IMG_W_DEF x IMG_H_DEF).
//   - 3x3 window bit positions: bit 3*r+c, r=0 top row, c=0 left column.
//   - win_t: the 9-bit window vector handed to MAC_UNIT a[8:0].
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;

  localparam int WIN_BITS = 9;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef logic [WIN_BITS-1:0] win_t;

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of 1-bit pixels. Asynchronous read and synchronous write at
// the same index, so a caller sees the old contents in the cycle it writes.
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write enable (one accepted pixel beat)
//   i_addr     column index
//   i_wr_data  pixel written at i_addr
//   o_rd_data  pixel currently stored at i_addr
// -----------------------------------------------------------------------------
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  logic          i_wr_data,
  output logic          o_rd_data
);

  logic r_mem [DEPTH];

  assign o_rd_data = r_mem[i_addr];

  // NOTE: storage has no reset; the first two lines of every frame overwrite
  // it before any window that depends on it can be emitted.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_addr] <= i_wr_data;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
// Streaming 3x3 sliding-window generator. Takes one binary pixel per accepted
// beat in raster order, keeps two previous lines, and emits every fully
// interior 3x3 window (stride 1, no padding) one cycle after the beat that
// completes it.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    pixel beat valid
//   in_pixel    pixel value
//   in_sof      beat is pixel (0,0); aborts any partial frame
//   in_ready    beat can be accepted (!out_valid || out_ready)
//   out_valid   out_win/out_row/out_col/out_last hold a window
//   out_win     window, bit 3*r+c (r=0 top, c=0 left)
//   out_row     row of window centre
//   out_col     column of window centre
//   out_last    last window of the frame
//   out_ready   downstream accepts the window
// -----------------------------------------------------------------------------
module window_gen_3x3
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_pixel,
  input  logic          in_sof,
  output logic          in_ready,
  output logic          out_valid,
  output win_t          out_win,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  input  logic          out_ready
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  win_t          r_win;

  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_qualify;
  logic          w_lb1;   // pixel one line above
  logic          w_lb2;   // pixel two lines above
  win_t          w_win_next;

  // Holding a window blocks input; taking it frees the slot in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Start of frame overrides the counters for the beat that carries it.
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;

  assign w_qualify = (w_row >= RW'(2)) && (w_col >= CW'(2));

  // Read-before-write lets line 1 cascade into line 2 at the same column.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_addr    (w_col),
    .i_wr_data (in_pixel),
    .o_rd_data (w_lb1)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_addr    (w_col),
    .i_wr_data (w_lb1),
    .o_rd_data (w_lb2)
  );

  // Shift window left; the new right column is {line2, line1, incoming}.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_win_next         = r_win;
    w_win_next[WIN_TL] = r_win[WIN_TC];
    w_win_next[WIN_TC] = r_win[WIN_TR];
    w_win_next[WIN_TR] = w_lb2;
    w_win_next[WIN_ML] = r_win[WIN_C];
    w_win_next[WIN_C]  = r_win[WIN_MR];
    w_win_next[WIN_MR] = w_lb1;
    w_win_next[WIN_BL] = r_win[WIN_BC];
    w_win_next[WIN_BC] = r_win[WIN_BR];
    w_win_next[WIN_BR] = in_pixel;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (w_accept) begin
      r_win <= w_win_next;
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
      // A non-qualifying beat still clears out_valid: the held window was
      // consumed, otherwise in_ready would have been low.
      out_valid <= w_qualify;
      if (w_qualify) begin
        out_row  <= w_row - RW'(1);
        out_col  <= w_col - CW'(1);
        out_last <= (w_row == ROW_LAST) && (w_col == COL_LAST);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_win = r_win;

endmodule
